// File: rtl/gpr_sweeper.sv
// gpr_sweeper: bulk initiator for the GPR 2R/1W port.
// FILL writes seed+idx to r1..r(NREG-1), CLEAR writes 0 to the same range,
// DUMP reads every register pair (rs=idx, rt=NREG-1-idx) and streams the
// captured data out. All outputs are registered.
// Optional self-check of dumped data: define GPR_SWEEP_CHECK_EN.
module gpr_sweeper #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_seed,
    output logic          gpr_reg_write,
    output logic [AW-1:0] gpr_num_write,
    output logic [DW-1:0] gpr_data_write,
    output logic [AW-1:0] gpr_rs,
    output logic [AW-1:0] gpr_rt,
    input  logic [DW-1:0] gpr_a,
    input  logic [DW-1:0] gpr_b,
    output logic          out_valid,
    output logic [AW-1:0] out_idx,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic          busy,
    output logic          done,
    output logic          mismatch
);

    localparam logic [1:0]    OP_FILL  = 2'b00;
    localparam logic [1:0]    OP_DUMP  = 2'b01;
    localparam logic [1:0]    OP_CLEAR = 2'b10;
    localparam logic [AW-1:0] IDX_LAST = AW'(NREG - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_CLEAR,
        S_DUMP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic [DW-1:0] seed;
    logic          cap_pend;   // a read address was presented last cycle
    logic          accept;
    logic          cap_now;

    assign accept  = (state == S_IDLE) && cmd_valid && cmd_ready;
    // gpr_a/gpr_b currently reflect the rs/rt registered on the previous edge
    assign cap_now = ((state == S_DUMP) && cap_pend) || (state == S_DRAIN);

    // Sweep sequencer: state, index counter and all registered GPR/stream outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            idx            <= '0;
            seed           <= '0;
            cap_pend       <= 1'b0;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            gpr_reg_write  <= 1'b0;
            gpr_num_write  <= '0;
            gpr_data_write <= '0;
            gpr_rs         <= '0;
            gpr_rt         <= '0;
            out_valid      <= 1'b0;
            out_idx        <= '0;
            out_a          <= '0;
            out_b          <= '0;
        end else begin
            done          <= 1'b0;
            out_valid     <= 1'b0;
            gpr_reg_write <= 1'b0;
            if (cap_now) begin
                out_valid <= 1'b1;
                out_idx   <= gpr_rs;
                out_a     <= gpr_a;
                out_b     <= gpr_b;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        seed      <= cmd_seed;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        case (cmd_op)
                            OP_FILL:  begin state <= S_FILL;  idx <= AW'(1); end
                            OP_CLEAR: begin state <= S_CLEAR; idx <= AW'(1); end
                            OP_DUMP:  begin state <= S_DUMP;  idx <= '0;     end
                            default:  state <= S_DONE;
                        endcase
                    end
                end
                S_FILL, S_CLEAR: begin
                    gpr_reg_write  <= 1'b1;
                    gpr_num_write  <= idx;
                    gpr_data_write <= (state == S_FILL) ? seed + DW'(idx) : '0;
                    if (idx == IDX_LAST) state <= S_DONE;
                    else                 idx   <= idx + AW'(1);
                end
                S_DUMP: begin
                    gpr_rs   <= idx;
                    gpr_rt   <= IDX_LAST - idx;
                    cap_pend <= 1'b1;
                    if (idx == IDX_LAST) state <= S_DRAIN;
                    else                 idx   <= idx + AW'(1);
                end
                S_DRAIN: begin
                    cap_pend <= 1'b0;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    done      <= 1'b1;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef GPR_SWEEP_CHECK_EN
    logic [DW-1:0] chk_seed;
    logic          chk_armed;
    logic          chk_clr;    // last write sweep was CLEAR: every entry reads 0
    logic [DW-1:0] chk_exp;

    // Expected contents of the register currently addressed by rs
    always_comb begin
        chk_exp = '0;
        if (gpr_rs != '0 && !chk_clr)
            chk_exp = chk_seed + DW'(gpr_rs);
    end

    // Remember the last write sweep and flag any dumped value that disagrees
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chk_seed  <= '0;
            chk_armed <= 1'b0;
            chk_clr   <= 1'b0;
            mismatch  <= 1'b0;
        end else if (accept && (cmd_op == OP_FILL || cmd_op == OP_CLEAR)) begin
            chk_seed  <= (cmd_op == OP_FILL) ? cmd_seed : '0;
            chk_clr   <= (cmd_op == OP_CLEAR);
            chk_armed <= 1'b1;
            mismatch  <= 1'b0;
        end else if (chk_armed && cap_now && (gpr_a != chk_exp)) begin
            mismatch <= 1'b1;
        end
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_gpr_sweeper.sv
// Scoreboard bench for gpr_sweeper with a behavioural GPR attached.
module tb_gpr_sweeper;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b11;
    logic [DW-1:0] cmd_seed = '0;
    logic          gpr_reg_write;
    logic [AW-1:0] gpr_num_write;
    logic [DW-1:0] gpr_data_write;
    logic [AW-1:0] gpr_rs, gpr_rt;
    logic [DW-1:0] gpr_a, gpr_b;
    logic          out_valid;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] out_a, out_b;
    logic          busy, done, mismatch;

    gpr_sweeper #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_seed(cmd_seed),
        .gpr_reg_write(gpr_reg_write), .gpr_num_write(gpr_num_write), .gpr_data_write(gpr_data_write),
        .gpr_rs(gpr_rs), .gpr_rt(gpr_rt), .gpr_a(gpr_a), .gpr_b(gpr_b),
        .out_valid(out_valid), .out_idx(out_idx), .out_a(out_a), .out_b(out_b),
        .busy(busy), .done(done), .mismatch(mismatch)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] idx;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          mm;
    } item_t;

    item_t         sb[$];
    int            done_q[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            ov_cnt = 0;
    logic [DW-1:0] exp_regs [NREG];
    logic [DW-1:0] regs [NREG];
    logic          force3 = 1'b0;
    logic          wrap_chk = 1'b0;

    // behavioural register file: r0 reads zero, combinational reads
    always @(posedge clock)
        if (gpr_reg_write && gpr_num_write != '0) regs[gpr_num_write] <= gpr_data_write;

    always_comb begin
        gpr_a = '0;
        gpr_b = '0;
        if (gpr_rs != '0) gpr_a = (force3 && gpr_rs == AW'(3)) ? '0 : regs[gpr_rs];
        if (gpr_rt != '0) gpr_b = (force3 && gpr_rt == AW'(3)) ? '0 : regs[gpr_rt];
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pops the scoreboard on every output strobe
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid) begin
                ov_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    item_t it;
                    it = sb.pop_front();
                    chk("out_idx", DW'(out_idx), DW'(it.idx));
                    chk("out_a", out_a, it.a);
                    chk("out_b", out_b, it.b);
                    chk("mismatch", DW'(mismatch), DW'(it.mm));
                end
                if (wrap_chk && out_idx == AW'(17)) chk("wrap_reg17", out_a, 32'h0000_0001);
            end
            if (done) begin
                if (done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else                    chk("done_cycle", DW'(cyc), DW'(done_q.pop_front()));
            end
            if (busy && cmd_ready) chk("ready_while_busy", 32'd1, 32'd0);
        end
    end

    function automatic logic [DW-1:0] exp_rd(input int r);
        if (r == 0 || (force3 && r == 3)) return '0;
        return exp_regs[r];
    endfunction

    task automatic push_dump();
        for (int i = 0; i < NREG; i++) begin
            item_t it;
            it.idx = AW'(i);
            it.a   = exp_rd(i);
            it.b   = exp_rd(NREG - 1 - i);
`ifdef GPR_SWEEP_CHECK_EN
            it.mm  = force3 && (i >= 3);
`else
            it.mm  = 1'b0;
`endif
            sb.push_back(it);
        end
    endtask

    task automatic set_exp(input logic [DW-1:0] s, input logic clr);
        exp_regs[0] = '0;
        for (int i = 1; i < NREG; i++) exp_regs[i] = clr ? '0 : s + DW'(i);
    endtask

    // issue one command from IDLE; queue its expected done cycle and dump data
    task automatic issue(input logic [1:0] op, input logic [DW-1:0] s, input logic expect_done);
        int k;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_seed  = s;
        @(posedge clock);
        #1;
        k = cyc;
        if (expect_done) begin
            case (op)
                2'b00, 2'b10: done_q.push_back(k + NREG);
                2'b01: begin push_dump(); done_q.push_back(k + NREG + 2); end
                default: done_q.push_back(k + 1);
            endcase
        end
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || done_q.size() != 0 || busy) && n < 300) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL wait_idle: timeout with sb=%0d done_q=%0d", sb.size(), done_q.size());
            sb.delete();
            done_q.delete();
        end
    endtask

    initial begin
        int k, n, ov0;
        // reset state
        #1 reset = 1'b1;
        #3;
        chk("rst_cmd_ready", DW'(cmd_ready), 32'd1);
        chk("rst_busy", DW'(busy), 32'd0);
        chk("rst_done", DW'(done), 32'd0);
        chk("rst_reg_write", DW'(gpr_reg_write), 32'd0);
        chk("rst_out_valid", DW'(out_valid), 32'd0);
        chk("rst_mismatch", DW'(mismatch), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // NOP: done one cycle after accept
        issue(2'b11, '0, 1'b1);
        wait_idle();

        // FILL seed 0, then DUMP
        set_exp(32'h0, 1'b0);
        issue(2'b00, 32'h0, 1'b1);
        wait_idle();
        ov0 = ov_cnt;
        issue(2'b01, '0, 1'b1);
        wait_idle();
        chk("dump_count_seed0", DW'(ov_cnt - ov0), DW'(NREG));

        // FILL with wrapping seed, then DUMP
        set_exp(32'hFFFF_FFF0, 1'b0);
        issue(2'b00, 32'hFFFF_FFF0, 1'b1);
        wait_idle();
        wrap_chk = 1'b1;
        issue(2'b01, '0, 1'b1);
        wait_idle();
        wrap_chk = 1'b0;

        // CLEAR then DUMP
        set_exp('0, 1'b1);
        issue(2'b10, 32'h1234_5678, 1'b1);
        wait_idle();
        issue(2'b01, '0, 1'b1);
        wait_idle();

        // back-to-back: cmd_valid held high across a DUMP
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        @(posedge clock);
        #1;
        k = cyc;
        push_dump();
        done_q.push_back(k + NREG + 2);
        push_dump();
        done_q.push_back(k + 2 * NREG + 5);
        ov0 = ov_cnt;
        while (cyc < k + NREG + 3) @(negedge clock);
        cmd_valid = 1'b0;
        wait_idle();
        chk("b2b_count", DW'(ov_cnt - ov0), DW'(2 * NREG));

        // reset mid-FILL at idx 7
        issue(2'b00, 32'h100, 1'b0);
        n = 0;
        while (!(gpr_reg_write && gpr_num_write == AW'(7)) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("reach_idx7", DW'(n < 100), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_reg_write", DW'(gpr_reg_write), 32'd0);
        chk("mid_rst_cmd_ready", DW'(cmd_ready), 32'd1);
        chk("mid_rst_busy", DW'(busy), 32'd0);
        chk("mid_rst_num_write", DW'(gpr_num_write), 32'd0);
        chk("mid_rst_data_write", gpr_data_write, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        chk("post_rst_idle", DW'(cmd_ready), 32'd1);

        // FILL seed 5, corrupt r3 on the read side, DUMP
        set_exp(32'd5, 1'b0);
        issue(2'b00, 32'd5, 1'b1);
        wait_idle();
        force3 = 1'b1;
        issue(2'b01, '0, 1'b1);
        wait_idle();
`ifdef GPR_SWEEP_CHECK_EN
        chk("mismatch_sticky", DW'(mismatch), 32'd1);
`else
        chk("mismatch_tied", DW'(mismatch), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
